// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the nibble-serial adder.
// The requester drives the operation; the adder returns handshake and result.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, c_in, a, b,
    input  ready, busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, sub, c_in, a, b,
    output ready, busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract through one 4-bit adder slice.
// One nibble per cycle, LSB first; a registered carry links the passes.

// 4-bit combinational slice: {c_out, s} = a + b + c_in
module nibble_serial_adder_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [NIBBLES-1:0][3:0] a_q;     // captured A
  logic [NIBBLES-1:0][3:0] b_q;     // captured B' (already inverted for sub)
  logic                    cin_q;   // carry into nibble 0
  logic                    carry_q; // carry out of the previous nibble
  logic [NIBBLES-1:0][3:0] part_q;  // partial result, filled LSB first
  logic [WIDTH-1:0]        sum_q;
  logic                    c_out_q;
  logic                    ovf_q;
  logic                    done_q;

  logic                    slice_cin;
  logic [3:0]              slice_s;
  logic                    slice_c;
  logic [NIBBLES-1:0][3:0] res_full;
  logic                    last;

  assign last      = (cnt == CW'(NIBBLES - 1));
  assign slice_cin = (cnt == '0) ? cin_q : carry_q;

  nibble_serial_adder_slice u_slice (
    .a     (a_q[cnt]),
    .b     (b_q[cnt]),
    .c_in  (slice_cin),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // Partial result with the nibble being processed this cycle merged in
  always_comb begin
    res_full      = part_q;
    res_full[cnt] = slice_s;
  end

  // Sequencer: capture on accept, one slice pass per RUN cycle, publish on the last pass
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      part_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.sub ? ~bus.b : bus.b;
            cin_q <= bus.sub ? 1'b1 : bus.c_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          part_q  <= res_full;
          carry_q <= slice_c;
          cnt     <= cnt + CW'(1);
          if (last) begin
            sum_q   <= res_full;
            c_out_q <= slice_c;
            // Same-sign operands producing an opposite-sign result
            ovf_q   <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                       (res_full[NIBBLES-1][3] != a_q[NIBBLES-1][3]);
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;
  logic clock;
  logic reset;
  int   nvec;
  int   nmis;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, track latency, check result and return to IDLE
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic ts, input logic tc,
                       input logic [15:0] es, input logic ec, input logic eo);
    logic [15:0] prev;
    int          lat;
    prev = bus.sum;
    @(negedge clock);
    bus.a = ta; bus.b = tb_v; bus.sub = ts; bus.c_in = tc; bus.start = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clock);
    bus.start = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.sub = ~ts; bus.c_in = ~tc;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      chk({tag, "_hold"}, 32'(bus.sum), 32'(prev));
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    @(posedge clock); #1;
    chk({tag, "_rdy"}, 32'(bus.ready), 32'd1);
    chk({tag, "_dn0"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int dones;
    int rdy_bad;
    nvec = 0; nmis = 0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.c_in = 1'b0; bus.a = '0; bus.b = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #3;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_sum",   32'(bus.sum),   32'd0);
    chk("rst_cout",  32'(bus.c_out), 32'd0);
    chk("rst_ovf",   32'(bus.ovf),   32'd0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);

    do_op("add1",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("ripple",16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("ovfadd",16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    do_op("sub1",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub2",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op("cin",   16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Handshake: start pulses during RUN and DONE must be ignored
    @(negedge clock);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); bus.start = 1'b0;
    @(negedge clock);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.sub = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    dones = 0; rdy_bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock); #1;
      if (bus.ready) rdy_bad++;
      if (bus.done) begin
        dones++;
        break;
      end
    end
    chk("hs_rdy_low", 32'(rdy_bad), 32'd0);
    chk("hs_sum", 32'(bus.sum), 32'h3333);
    @(negedge clock);
    bus.start = 1'b1; bus.a = 16'h0F00; bus.b = 16'h00F0; bus.sub = 1'b0;
    @(posedge clock); #1;
    chk("hs_idle", 32'(bus.ready), 32'd1);
    @(negedge clock); bus.start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
      if (!bus.ready) rdy_bad++;
    end
    chk("hs_dones", 32'(dones), 32'd1);
    chk("hs_stay_idle", 32'(rdy_bad), 32'd0);
    chk("hs_sum_kept", 32'(bus.sum), 32'h3333);

    // Reset mid-RUN (cnt=2): outputs clear at once, no done follows
    @(negedge clock);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.start = 1'b1;
    @(posedge clock);
    @(negedge clock); bus.start = 1'b0;
    @(posedge clock);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("ar_ready", 32'(bus.ready), 32'd1);
    chk("ar_busy",  32'(bus.busy),  32'd0);
    chk("ar_sum",   32'(bus.sum),   32'd0);
    chk("ar_cout",  32'(bus.c_out), 32'd0);
    chk("ar_done",  32'(bus.done),  32'd0);
    @(negedge clock); reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    chk("ar_no_done", 32'(dones), 32'd0);
    do_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
